// File: rtl/rv_mc_ctrl_pkg.sv
// Shared types for the multicycle RV control FSM: state, opcode, and datapath select encodings.
package rv_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StReset,
        StFetch,
        StIwait,
        StDecode,
        StExecR,
        StExecI,
        StAluWb,
        StLuiWb,
        StMemAddr,
        StDreqRd,
        StDwait,
        StLoadWb,
        StDreqWr,
        StBranch,
        StTrap
    } mc_state_e;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpOpImm  = 7'b0010011,
        OpStore  = 7'b0100011,
        OpOp     = 7'b0110011,
        OpLui    = 7'b0110111,
        OpBranch = 7'b1100011
    } opcode_e;

    typedef enum logic {
        PcSelPlus4  = 1'b0,
        PcSelBranch = 1'b1
    } pc_sel_e;

    typedef enum logic [1:0] {
        WbAlu  = 2'b00,
        WbLoad = 2'b01,
        WbImm  = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluFunct = 2'b10
    } alu_op_e;

    // States that sit on an external memory handshake and are covered by the watchdog.
    function automatic logic is_wait_state(input mc_state_e s);
        return s inside {StFetch, StIwait, StDreqRd, StDwait, StDreqWr};
    endfunction

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// Instruction and data memory req/gnt/rvalid handshake bundle between the core control and memory.
interface rv_mc_ctrl_if;

    logic imem_req;
    logic imem_gnt;
    logic imem_rvalid;
    logic dmem_req;
    logic dmem_we;
    logic dmem_gnt;
    logic dmem_rvalid;

    modport master (
        output imem_req,
        input  imem_gnt,
        input  imem_rvalid,
        output dmem_req,
        output dmem_we,
        input  dmem_gnt,
        input  dmem_rvalid
    );

    modport slave (
        input  imem_req,
        output imem_gnt,
        output imem_rvalid,
        input  dmem_req,
        input  dmem_we,
        output dmem_gnt,
        output dmem_rvalid
    );

endinterface

// File: rtl/rv_mc_watchdog.sv
// Counts consecutive memory-wait cycles; pulses timeout_o on the MAX_WAIT-th cycle of one wait.
module rv_mc_watchdog #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic waiting_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CntW-1:0] cnt_d, cnt_q;

    // cnt_q holds the number of earlier cycles already spent in the current wait.
    assign timeout_o = waiting_i && (cnt_q == CntW'(MAX_WAIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !waiting_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback over a shared datapath.
// Optional performance counters are built only when RV_MC_PERF_EN is defined.
module rv_mc_ctrl
    import rv_mc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    rv_mc_ctrl_if.master     mem_if,
    input  logic [6:0]       opcode_i,
    input  logic             alu_zero_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic [1:0]       alu_op_o,
    output logic             alu_b_sel_o,
    output logic             rd_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             retire_o,
    output logic             trap_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o
);

    mc_state_e state_d, state_q;
    logic      bus_err_d, bus_err_q;
    logic      wd_waiting, wd_clear, wd_timeout;
    pc_sel_e   pc_sel;
    alu_op_e   alu_op;
    wb_sel_e   wb_sel;

    assign wd_waiting = is_wait_state(state_q);
    assign wd_clear   = (state_d != state_q);

    rv_mc_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .waiting_i (wd_waiting),
        .clear_i   (wd_clear),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d         = state_q;
        bus_err_d       = bus_err_q;
        mem_if.imem_req = 1'b0;
        mem_if.dmem_req = 1'b0;
        mem_if.dmem_we  = 1'b0;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel          = PcSelPlus4;
        alu_op          = AluAdd;
        alu_b_sel_o     = 1'b0;
        rd_we_o         = 1'b0;
        wb_sel          = WbAlu;
        retire_o        = 1'b0;

        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                mem_if.imem_req = 1'b1;
                if (mem_if.imem_gnt) state_d = StIwait;
            end
            StIwait: begin
                if (mem_if.imem_rvalid) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (opcode_i)
                    OpOp:             state_d = StExecR;
                    OpOpImm:          state_d = StExecI;
                    OpLoad, OpStore:  state_d = StMemAddr;
                    OpBranch:         state_d = StBranch;
                    OpLui:            state_d = StLuiWb;
                    default:          state_d = StTrap;
                endcase
            end
            StExecR: begin
                alu_op  = AluFunct;
                state_d = StAluWb;
            end
            StExecI: begin
                alu_op      = AluFunct;
                alu_b_sel_o = 1'b1;
                state_d     = StAluWb;
            end
            StAluWb: begin
                rd_we_o  = 1'b1;
                retire_o = 1'b1;
                state_d  = StFetch;
            end
            StLuiWb: begin
                rd_we_o  = 1'b1;
                wb_sel   = WbImm;
                retire_o = 1'b1;
                state_d  = StFetch;
            end
            StMemAddr: begin
                alu_b_sel_o = 1'b1;
                state_d     = (opcode_i == OpStore) ? StDreqWr : StDreqRd;
            end
            StDreqRd: begin
                mem_if.dmem_req = 1'b1;
                if (mem_if.dmem_gnt) state_d = StDwait;
            end
            StDwait: begin
                if (mem_if.dmem_rvalid) state_d = StLoadWb;
            end
            StLoadWb: begin
                rd_we_o  = 1'b1;
                wb_sel   = WbLoad;
                retire_o = 1'b1;
                state_d  = StFetch;
            end
            StDreqWr: begin
                mem_if.dmem_req = 1'b1;
                mem_if.dmem_we  = 1'b1;
                // A store has nothing to write back, so acceptance completes it.
                if (mem_if.dmem_gnt) begin
                    retire_o = 1'b1;
                    state_d  = StFetch;
                end
            end
            StBranch: begin
                alu_op   = AluSub;
                pc_we_o  = alu_zero_i;
                pc_sel   = alu_zero_i ? PcSelBranch : PcSelPlus4;
                retire_o = 1'b1;
                state_d  = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // A handshake that makes progress on its last allowed cycle is not a timeout.
        if (wd_timeout && (state_d == state_q)) begin
            state_d   = StTrap;
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StReset;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign pc_sel_o  = pc_sel;
    assign alu_op_o  = alu_op;
    assign wb_sel_o  = wb_sel;
    assign trap_o    = (state_q == StTrap);
    assign bus_err_o = bus_err_q;

`ifdef RV_MC_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_d, cycle_cnt_q;
    logic [CNT_W-1:0] instret_cnt_d, instret_cnt_q;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        instret_cnt_d = instret_cnt_q;
        if (retire_o) instret_cnt_d = instret_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`else
    assign cycle_cnt_o   = '0;
    assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed bench for rv_mc_ctrl: per-instruction vector table plus reset, trap and watchdog sequences.
module tb_rv_mc_ctrl;

    localparam int CNT_W = 32;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rst_ni, rst2_ni;
    logic [6:0]       opcode;
    logic             alu_zero;

    logic             ir_we, pc_we, pc_sel, alu_b_sel, rd_we, retire, trap, bus_err;
    logic [1:0]       alu_op, wb_sel;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt;

    logic             ir_we2, pc_we2, pc_sel2, alu_b_sel2, rd_we2, retire2, trap2, bus_err2;
    logic [1:0]       alu_op2, wb_sel2;
    logic [CNT_W-1:0] cyc_cnt2, ret_cnt2;

    rv_mc_ctrl_if mem_if ();
    rv_mc_ctrl_if mem2_if ();

    rv_mc_ctrl #(.MAX_WAIT(255), .CNT_W(CNT_W)) u_dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .mem_if (mem_if.master),
        .opcode_i (opcode), .alu_zero_i (alu_zero),
        .ir_we_o (ir_we), .pc_we_o (pc_we), .pc_sel_o (pc_sel), .alu_op_o (alu_op),
        .alu_b_sel_o (alu_b_sel), .rd_we_o (rd_we), .wb_sel_o (wb_sel), .retire_o (retire),
        .trap_o (trap), .bus_err_o (bus_err), .cycle_cnt_o (cyc_cnt), .instret_cnt_o (ret_cnt)
    );

    rv_mc_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) u_dut_wd (
        .clk_i (clk_i), .rst_ni (rst2_ni), .mem_if (mem2_if.master),
        .opcode_i (opcode), .alu_zero_i (alu_zero),
        .ir_we_o (ir_we2), .pc_we_o (pc_we2), .pc_sel_o (pc_sel2), .alu_op_o (alu_op2),
        .alu_b_sel_o (alu_b_sel2), .rd_we_o (rd_we2), .wb_sel_o (wb_sel2), .retire_o (retire2),
        .trap_o (trap2), .bus_err_o (bus_err2), .cycle_cnt_o (cyc_cnt2),
        .instret_cnt_o (ret_cnt2)
    );

    typedef struct {
        int         lat;
        int         ireq;
        int         pcwe_n;
        logic       rd_we;
        logic [1:0] wb_sel;
        logic       pc_sel;
        logic       st;
        logic [1:0] alu_op;
        logic       b_sel;
    } res_t;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        int         gd;
        res_t       exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [6:0] op, input logic zero, input int gd,
                                 input int lat, input int ireq, input int pcwe_n,
                                 input logic rdw, input logic [1:0] wb, input logic pcs,
                                 input logic st, input logic [1:0] aop, input logic bs);
        vec_t v;
        v.op = op; v.zero = zero; v.gd = gd;
        v.exp.lat = lat; v.exp.ireq = ireq; v.exp.pcwe_n = pcwe_n; v.exp.rd_we = rdw;
        v.exp.wb_sel = wb; v.exp.pc_sel = pcs; v.exp.st = st; v.exp.alu_op = aop;
        v.exp.b_sel = bs;
        return v;
    endfunction

    // Zero-wait memory responder (imem gnt optionally delayed); cycle 1 is the first FETCH cycle.
    task automatic run_instr(input logic [6:0] op, input logic zero, input int gd,
                             input int max_cyc, output res_t r);
        int   cyc = 0;
        int   gwait = 0;
        int   ir_cyc = -10;
        logic ipend = 1'b0;
        logic dpend = 1'b0;
        r.lat = -1; r.ireq = 0; r.pcwe_n = 0; r.rd_we = 1'b0; r.wb_sel = 2'b00;
        r.pc_sel = 1'b0; r.st = 1'b0; r.alu_op = 2'b00; r.b_sel = 1'b0;
        opcode   = op;
        alu_zero = zero;
        while (cyc < max_cyc) begin
            @(negedge clk_i);
            cyc++;
            mem_if.imem_rvalid = ipend;
            ipend              = 1'b0;
            mem_if.imem_gnt    = mem_if.imem_req && (gwait >= gd);
            if (mem_if.imem_req && !mem_if.imem_gnt) gwait++;
            if (mem_if.imem_gnt) ipend = 1'b1;
            mem_if.dmem_rvalid = dpend;
            dpend              = 1'b0;
            mem_if.dmem_gnt    = mem_if.dmem_req;
            if (mem_if.dmem_gnt && !mem_if.dmem_we) dpend = 1'b1;
            #1;
            if (mem_if.imem_req) r.ireq++;
            if (pc_we) r.pcwe_n++;
            if (ir_we) ir_cyc = cyc;
            if (cyc == ir_cyc + 2) begin
                r.alu_op = alu_op;
                r.b_sel  = alu_b_sel;
            end
            if (retire) begin
                r.lat    = cyc;
                r.rd_we  = rd_we;
                r.wb_sel = wb_sel;
                r.pc_sel = pc_sel;
                r.st     = mem_if.dmem_we;
                break;
            end
        end
    endtask

    task automatic clear_inputs();
        mem_if.imem_gnt = 1'b0; mem_if.imem_rvalid = 1'b0;
        mem_if.dmem_gnt = 1'b0; mem_if.dmem_rvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outs"}, longint'({mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_we,
              pc_we, pc_sel, alu_op, alu_b_sel, rd_we, wb_sel, retire, trap, bus_err}), 0);
        check({tag, ".cycle_cnt"}, longint'(cyc_cnt), 0);
        check({tag, ".instret_cnt"}, longint'(ret_cnt), 0);
    endtask

    vec_t vecs[8];
    res_t r;

    initial begin
        rst_ni = 1'b0; rst2_ni = 1'b0; opcode = 7'd0; alu_zero = 1'b0;
        clear_inputs();
        mem2_if.imem_gnt = 1'b0; mem2_if.imem_rvalid = 1'b0;
        mem2_if.dmem_gnt = 1'b0; mem2_if.dmem_rvalid = 1'b0;

        //             op          z   gd lat ireq pcwe rdw wb     pcs  st   aop    bs
        vecs[0] = mkv(7'b0110011, 0, 0, 5,  1,   1,   1, 2'b00, 0,   0, 2'b10, 0); // ADD
        vecs[1] = mkv(7'b0010011, 0, 0, 5,  1,   1,   1, 2'b00, 0,   0, 2'b10, 1); // ADDI
        vecs[2] = mkv(7'b0000011, 0, 3, 10, 4,   1,   1, 2'b01, 0,   0, 2'b00, 1); // LW slow
        vecs[3] = mkv(7'b0100011, 0, 0, 5,  1,   1,   0, 2'b00, 0,   1, 2'b00, 1); // SW
        vecs[4] = mkv(7'b1100011, 1, 0, 4,  1,   2,   0, 2'b00, 1,   0, 2'b01, 0); // BEQ taken
        vecs[5] = mkv(7'b1100011, 0, 0, 4,  1,   1,   0, 2'b00, 0,   0, 2'b01, 0); // BEQ not
        vecs[6] = mkv(7'b0110111, 0, 0, 4,  1,   1,   1, 2'b10, 0,   0, 2'b00, 0); // LUI
        vecs[7] = mkv(7'b0000011, 0, 0, 7,  1,   1,   1, 2'b01, 0,   0, 2'b00, 1); // LW fast

        repeat (2) @(negedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_instr(vecs[i].op, vecs[i].zero, vecs[i].gd, 30, r);
            check($sformatf("v%0d.latency", i), r.lat, vecs[i].exp.lat);
            check($sformatf("v%0d.imem_req_cycles", i), r.ireq, vecs[i].exp.ireq);
            check($sformatf("v%0d.pc_we_pulses", i), r.pcwe_n, vecs[i].exp.pcwe_n);
            check($sformatf("v%0d.rd_we", i), r.rd_we, vecs[i].exp.rd_we);
            check($sformatf("v%0d.wb_sel", i), r.wb_sel, vecs[i].exp.wb_sel);
            check($sformatf("v%0d.pc_sel", i), r.pc_sel, vecs[i].exp.pc_sel);
            check($sformatf("v%0d.dmem_we", i), r.st, vecs[i].exp.st);
            check($sformatf("v%0d.alu_op", i), r.alu_op, vecs[i].exp.alu_op);
            check($sformatf("v%0d.alu_b_sel", i), r.b_sel, vecs[i].exp.b_sel);
        end
        check("no_trap_after_table", {trap, bus_err}, 0);

        // Illegal opcode: one fetch, then TRAP forever; stray grants are ignored.
        run_instr(7'b1111111, 1'b0, 0, 20, r);
        check("illegal.no_retire", r.lat, -1);
        check("illegal.imem_req_cycles", r.ireq, 1);
        check("illegal.trap", trap, 1);
        check("illegal.bus_err", bus_err, 0);
        @(negedge clk_i);
        mem_if.imem_gnt = 1'b1; mem_if.dmem_gnt = 1'b1; mem_if.imem_rvalid = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("illegal.stray_gnt", {mem_if.imem_req, mem_if.dmem_req, ir_we, pc_we, trap}, 1);

        // Reset during DWAIT, stray rvalid in FETCH, then ten ADDs.
        @(negedge clk_i);
        clear_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_instr(7'b0000011, 1'b0, 0, 5, r);
        check("dwait.reached_dreq", r.lat, -1);
        @(negedge clk_i);
        clear_inputs();
        rst_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        mem_if.imem_rvalid = 1'b1;
        #1;
        check("stray_rvalid.fetch", {mem_if.imem_req, ir_we, pc_we}, 3'b100);
        @(negedge clk_i);
        mem_if.imem_rvalid = 1'b0;
        #1;
        check("stray_rvalid.still_fetch", {mem_if.imem_req, ir_we}, 2'b10);
        for (int k = 0; k < 10; k++) begin
            run_instr(7'b0110011, 1'b0, 0, 30, r);
            check($sformatf("add%0d.latency", k), r.lat, 5);
        end
`ifdef RV_MC_PERF_EN
        check("instret_after_10_adds", longint'(ret_cnt), 10);
`else
        check("instret_tied_zero", longint'(ret_cnt), 0);
        check("cycle_tied_zero", longint'(cyc_cnt), 0);
`endif

        // Watchdog instance: load whose data request is never granted.
        begin
            int   cyc = 0;
            int   dreq_n = 0;
            int   trap_cyc = -1;
            logic ip2 = 1'b0;
            opcode = 7'b0000011;
            @(negedge clk_i);
            rst2_ni = 1'b1;
            while (cyc < 20) begin
                @(negedge clk_i);
                cyc++;
                mem2_if.imem_rvalid = ip2;
                ip2                 = 1'b0;
                mem2_if.imem_gnt    = mem2_if.imem_req;
                if (mem2_if.imem_gnt) ip2 = 1'b1;
                mem2_if.dmem_gnt    = 1'b0;
                mem2_if.dmem_rvalid = 1'b0;
                #1;
                if (mem2_if.dmem_req) dreq_n++;
                if (trap2 && trap_cyc < 0) trap_cyc = cyc;
            end
            check("wd.dmem_req_cycles", dreq_n, 4);
            check("wd.trap_cycle", trap_cyc, 9);
            check("wd.bus_err", bus_err2, 1);
            check("wd.trap_held", trap2, 1);
            check("wd.no_requests", {mem2_if.imem_req, mem2_if.dmem_req, retire2}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
